multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control sequencer for the impostor_32 multicycle RV32I core. It fetches each instruction through a ready/valid instruction-memory port and decodes the opcode class. It then walks the shared datapath through FETCH/DECODE/EXEC/MEM/WB, driving `alu_op`/`alu_en_n` to `alu_control` and the register-file, PC and data-memory strobes. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value `pc_init` presents for the datapath PC reload after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one cycle is sufficient.
- `instr`  in  32  instruction word from the datapath IR mux, valid while `imem_ready`=1 in FETCH and held in the IR afterwards.
- `imem_req`  out  1  instruction fetch request.
- `imem_ready`  in  1  fetch complete this cycle.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`=1.
- `dmem_ready`  in  1  data access complete this cycle.
- `branch_taken`  in  1  comparator result from the datapath, sampled in EXEC.
- `ir_we`  out  1  capture `instr` into the IR.
- `alu_op`  out  2  00 R-type, 01 I-type ALU, 10 load/store address, 11 branch compare.
- `alu_en_n`  out  1  active-low ALU-control enable.
- `alu_src_b`  out  1  0 = rs2, 1 = immediate.
- `rf_we`  out  1  register-file write strobe.
- `wb_sel`  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 immediate (LUI).
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  2  00 PC+4, 01 PC+imm (branch, JAL, AUIPC base), 10 ALU result & ~1 (JALR).
- `pc_init`  out  32  constant `RESET_PC`.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `instret`  out  32  count of retired instructions.
- `trap`  out  1  illegal-opcode indicator (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH
  - `imem_req`=1 until `imem_ready`; in the `imem_ready` cycle, `ir_we`=1 and go to DECODE.
- DECODE
  - Classify `instr[6:0]`: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Go to EXEC.
- EXEC
  - `alu_en_n`=0 for one cycle. `alu_op`/`alu_src_b` by class: R 00/0, I 01/1, LOAD/STORE 10/1, BRANCH 11/0, JALR 01/1.
  - BRANCH: `pc_we`=1, `pc_sel`=01 if `branch_taken` else 00; `retire`; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM
  - `dmem_req`=1, `dmem_we`=1 for STORE, until `dmem_ready`.
  - STORE completes with `pc_we`=1, `pc_sel`=00, `retire`; go to FETCH.
  - LOAD goes to WB.
- WB
  - `rf_we`=1 and `pc_we`=1, with `wb_sel`/`pc_sel` by class: R/I 00/00, LOAD 01/00, JAL 10/01, JALR 10/10, LUI 11/00, AUIPC 00/00.
  - `retire`; go to FETCH.
- AUIPC: EXEC forces `alu_op`=10 with datapath operand A = PC.
- All strobes are decoded from state and class; they are 0 outside the cycles listed.
- `instret` increments by 1 on every `retire`; it wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - state FETCH.
  - `instret` 0.
  - `trap` 0.
  - All strobes (`imem_req`, `dmem_req`, `dmem_we`, `ir_we`, `rf_we`, `pc_we`, `retire`) 0 during reset.
  - `alu_en_n` 1.
  - `alu_op`, `wb_sel`, `pc_sel`, `alu_src_b` 0.
- Reset asserted in any state, including mid-wait with `imem_req`/`dmem_req` high, returns to FETCH on the next edge.
- First `imem_req` is asserted in the cycle after `reset` deasserts.
- Cycles per instruction with zero-wait memory (`ready` in the same cycle as `req`): BRANCH 3, R/I/JAL/JALR/LUI/AUIPC 4, STORE 4, LOAD 5. Each memory wait cycle adds 1.
- Handshake: `req` remains high and stable until the `ready` cycle. `ready` arriving while `req`=0 is ignored.

## Configuration
- `MCTRL_TRAP_EN` defined:
  - An unrecognised opcode in DECODE goes to TRAP. `trap`=1 is sticky and no further requests are issued until `reset`.
- `MCTRL_TRAP_EN` undefined:
  - An unrecognised opcode is treated as a NOP: DECODE→WB with `rf_we`=0, `pc_we`=1, `pc_sel`=00 and `retire`=1.
  - `trap` is tied to 0.

## Structure
- Shared package `impostor_pkg`:
  - State enum.
  - Opcode constants.
  - `alu_op`, `wb_sel` and `pc_sel` encodings, which `alu_control` also uses.
- One sub-module, `opcode_decoder`: combinational `instr[6:0]` → class one-hot plus illegal flag.
- FSM, strobe decode and `instret` stay in `multicycle_ctrl`.

## Test plan
- Reset, then zero-wait R-type `add` (32'h002081B3) → FETCH/DECODE/EXEC/WB over 4 cycles; `alu_op`=00 and `alu_en_n`=0 in cycle 3; `rf_we`=1, `retire`=1 in cycle 4; `instret`=1.
- LOAD `lw` with `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles, `dmem_we`=0; WB with `wb_sel`=01; total 8 cycles.
- BRANCH `beq`, first with `branch_taken`=1 then with 0 → `pc_sel`=01 then 00; `pc_we`=1 and `retire`=1 in EXEC; 3 cycles each.
- `reset` pulsed while in MEM with `dmem_req`=1 → next cycle all strobes 0, state FETCH, `instret`=0.
- Opcode 7'b1111111 → with `MCTRL_TRAP_EN`, `trap`=1 and `imem_req` stays 0 thereafter; without it, NOP retire and the fetch continues.
- `instret` forced to 32'hFFFF_FFFF, then one retire → 0.

Source files
------------

// File: rtl/impostor_pkg.sv
// impostor_pkg: shared state, opcode, class and datapath-select encodings for the impostor_32 control path
package impostor_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] ALU_R     = 2'b00;
  localparam logic [1:0] ALU_I     = 2'b01;
  localparam logic [1:0] ALU_MEM   = 2'b10;
  localparam logic [1:0] ALU_BR    = 2'b11;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;
  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } cls_t;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: maps instr[6:0] to a one-hot instruction class plus an illegal flag
module opcode_decoder
  import impostor_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_t       o_cls,
  output logic       o_illegal
);
  assign o_cls.r      = i_opcode == OP_R;
  assign o_cls.i      = i_opcode == OP_I;
  assign o_cls.load   = i_opcode == OP_LOAD;
  assign o_cls.store  = i_opcode == OP_STORE;
  assign o_cls.branch = i_opcode == OP_BRANCH;
  assign o_cls.jal    = i_opcode == OP_JAL;
  assign o_cls.jalr   = i_opcode == OP_JALR;
  assign o_cls.lui    = i_opcode == OP_LUI;
  assign o_cls.auipc  = i_opcode == OP_AUIPC;
  assign o_illegal    = ~|o_cls;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter; MCTRL_TRAP_EN makes illegal opcodes trap
module multicycle_ctrl
  import impostor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic [1:0]  alu_op,
  output logic        alu_en_n,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_init,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap
);
  state_t      r_state, w_next;
  cls_t        r_cls, w_cls;
  logic        w_illegal;
  logic [31:0] r_instret;
  logic        w_unused;
  assign w_unused = ^instr[31:7];
  assign pc_init  = RESET_PC;
  assign instret  = r_instret;
  opcode_decoder u_dec (
    .i_opcode (instr[6:0]),
    .o_cls    (w_cls),
    .o_illegal(w_illegal)
  );
  // state register
  always_ff @(posedge clk) r_state <= reset ? S_FETCH : w_next;
  // latch the class in DECODE so later states use it after instr changes
  always_ff @(posedge clk)
    if (reset) r_cls <= '0;
    else if (r_state == S_DECODE) r_cls <= w_cls;
  // retire counter; unconditional add keeps the update path single
  always_ff @(posedge clk) r_instret <= reset ? '0 : r_instret + {31'd0, retire};
  // next state and strobes from state and class; everything quiet while in reset
  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    alu_op    = ALU_R;
    alu_en_n  = 1'b1;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        w_next   = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
`ifdef MCTRL_TRAP_EN
        w_next = w_illegal ? S_TRAP : S_EXEC;
`else
        w_next = w_illegal ? S_WB : S_EXEC;
`endif
      end
      S_EXEC: begin
        alu_en_n  = 1'b0;
        alu_op    = r_cls.branch ? ALU_BR :
                    (r_cls.load | r_cls.store | r_cls.auipc) ? ALU_MEM :
                    (r_cls.i | r_cls.jalr) ? ALU_I : ALU_R;
        alu_src_b = r_cls.i | r_cls.load | r_cls.store | r_cls.jalr | r_cls.auipc;
        pc_we     = r_cls.branch;
        pc_sel    = (r_cls.branch & branch_taken) ? PC_IMM : PC_PLUS4;
        retire    = r_cls.branch;
        w_next    = r_cls.branch ? S_FETCH : (r_cls.load | r_cls.store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_cls.store;
        pc_we    = dmem_ready & r_cls.store;
        retire   = dmem_ready & r_cls.store;
        w_next   = !dmem_ready ? S_MEM : r_cls.store ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we  = |r_cls;
        pc_we  = 1'b1;
        wb_sel = r_cls.load ? WB_MEM : (r_cls.jal | r_cls.jalr) ? WB_PC4 : r_cls.lui ? WB_IMM : WB_ALU;
        pc_sel = r_cls.jal ? PC_IMM : r_cls.jalr ? PC_ALU : PC_PLUS4;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      alu_op    = ALU_R;
      alu_en_n  = 1'b1;
      alu_src_b = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      retire    = 1'b0;
    end
  end
`ifdef MCTRL_TRAP_EN
  assign trap = !reset && r_state == S_TRAP;
`else
  assign trap = 1'b0;
`endif
endmodule
